// File: rtl/fet_align_pkg.sv
// Shared fetch definitions: alignment FSM encoding, RV32/RV16 predicate, constants.
package fet_align_pkg;

   typedef enum logic [1:0] {
      StAlign = 2'd0,
      StOdd   = 2'd1,
      StCross = 2'd2
   } fet_state_e;

   localparam logic [31:0] InstrNop = 32'h0000_0013;
   localparam logic [31:0] Zero32   = 32'h0000_0000;
   localparam logic [15:0] Zero16   = 16'h0000;

   function automatic logic is_rv32(input logic [15:0] half);
      return half[1:0] == 2'b11;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fet_align_if.sv
// Fetch-alignment bus: redirect/stall control, instruction memory, decode-side outputs.
interface fet_align_if;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fet_stall;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] fetch_pc;
   logic [31:0] rv32_instr_todec;
   logic [15:0] rv16_instr_todec;
   logic        fe2de_rv16;
   logic        cross_bd_ff;
   logic        fet_valid;

   // slave: the alignment stage; master: the surrounding core / memory.
   modport slave (
      input  redirect, redirect_pc, fet_stall, imem_rdata,
      output imem_addr, fetch_pc, rv32_instr_todec, rv16_instr_todec,
             fe2de_rv16, cross_bd_ff, fet_valid
   );

   modport master (
      output redirect, redirect_pc, fet_stall, imem_rdata,
      input  imem_addr, fetch_pc, rv32_instr_todec, rv16_instr_todec,
             fe2de_rv16, cross_bd_ff, fet_valid
   );

endinterface

// File: rtl/fet_align.sv
// Fetch-alignment stage: splits 32-bit memory words into RV32/RV16 instructions,
// stitching 32-bit instructions that straddle a word boundary.
module fet_align
   import fet_align_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        cpurst_n,
   fet_align_if.slave bus
);

   fet_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [15:0] lo_buf_q, lo_buf_d;

   logic        consume;
   logic [15:0] half_lo, half_hi;
   logic [31:0] imem_addr;
   logic [31:0] fetch_pc;
   logic [31:0] rv32_instr;
   logic [15:0] rv16_instr;
   logic        is_rv16;
   logic        cross_bd;
   logic        valid;

   logic unused_rpc_bit;
   assign unused_rpc_bit = bus.redirect_pc[0];

   assign half_lo = bus.imem_rdata[15:0];
   assign half_hi = bus.imem_rdata[31:16];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      lo_buf_d   = lo_buf_q;
      consume    = 1'b0;
      valid      = 1'b0;
      rv32_instr = Zero32;
      rv16_instr = Zero16;
      is_rv16    = 1'b0;
      cross_bd   = 1'b0;
      fetch_pc   = pc_q;

      case (state_q)
         StAlign: begin
            valid = 1'b1;
            if (is_rv32(half_lo)) begin
               rv32_instr = bus.imem_rdata;
               pc_d       = pc_q + 32'd4;
               consume    = 1'b1;
            end else begin
               rv32_instr = {Zero16, half_lo};
               rv16_instr = half_lo;
               is_rv16    = 1'b1;
               pc_d       = pc_q + 32'd2;
               state_d    = StOdd;
            end
         end
         StOdd: begin
            consume = 1'b1;
            if (!is_rv32(half_hi)) begin
               valid      = 1'b1;
               rv32_instr = {Zero16, half_hi};
               rv16_instr = half_hi;
               is_rv16    = 1'b1;
               pc_d       = pc_q + 32'd2;
               state_d    = StAlign;
            end else begin
               // Low half of a straddling instruction; the high half is in the next word.
               lo_buf_d = half_hi;
               cross_bd = 1'b1;
               state_d  = StCross;
            end
         end
         StCross: begin
            valid      = 1'b1;
            rv32_instr = {half_lo, lo_buf_q};
            pc_d       = pc_q + 32'd4;
            state_d    = StOdd;
         end
         default: begin
            state_d = StAlign;
         end
      endcase

      if (bus.fet_stall) begin
         state_d  = state_q;
         pc_d     = pc_q;
         lo_buf_d = lo_buf_q;
         consume  = 1'b0;
      end

      // Redirect overrides stall and squashes whatever is on the outputs.
      if (bus.redirect) begin
         pc_d     = {bus.redirect_pc[31:1], 1'b0};
         lo_buf_d = lo_buf_q;
         consume  = 1'b0;
         if (bus.redirect_pc[1]) begin
            state_d = StOdd;
         end else begin
            state_d = StAlign;
         end
         valid      = 1'b0;
         rv32_instr = Zero32;
         rv16_instr = Zero16;
         is_rv16    = 1'b0;
         cross_bd   = 1'b0;
      end

      if (bus.redirect) begin
         imem_addr = word_align(bus.redirect_pc);
      end else if (consume) begin
         imem_addr = rd_addr_q + 32'd4;
      end else begin
         imem_addr = rd_addr_q;
      end
      rd_addr_d = imem_addr;

      if (!cpurst_n) begin
         imem_addr  = word_align(RESET_PC);
         fetch_pc   = RESET_PC;
         valid      = 1'b0;
         rv32_instr = Zero32;
         rv16_instr = Zero16;
         is_rv16    = 1'b0;
         cross_bd   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!cpurst_n) begin
         pc_q      <= RESET_PC;
         rd_addr_q <= word_align(RESET_PC);
         lo_buf_q  <= Zero16;
         if (RESET_PC[1]) begin
            state_q <= StOdd;
         end else begin
            state_q <= StAlign;
         end
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         rd_addr_q <= rd_addr_d;
         lo_buf_q  <= lo_buf_d;
      end
   end

   assign bus.imem_addr        = imem_addr;
   assign bus.fetch_pc         = fetch_pc;
   assign bus.rv32_instr_todec = rv32_instr;
   assign bus.rv16_instr_todec = rv16_instr;
   assign bus.fe2de_rv16       = is_rv16;
   assign bus.cross_bd_ff      = cross_bd;
   assign bus.fet_valid        = valid;

endmodule

// File: tb/tb_fet_align.sv
// Bench for fet_align: directed scenarios plus random stream checked against an
// instruction-stream model over a halfword view of memory.
module tb_fet_align;

   logic clk;
   logic cpurst_n;
   int   errors;
   int   checks;

   logic [31:0] mem [128];

   fet_align_if bus ();

   fet_align #(
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk     (clk),
      .cpurst_n(cpurst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous memory.
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[8:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] i32, input logic [15:0] i16,
                             input logic c16, input logic cb, input logic [31:0] addr);
      chk({tag, ".valid"}, 32'(bus.fet_valid), 32'(v));
      chk({tag, ".pc"}, bus.fetch_pc, pc);
      chk({tag, ".rv32"}, bus.rv32_instr_todec, i32);
      chk({tag, ".rv16"}, 32'(bus.rv16_instr_todec), 32'(i16));
      chk({tag, ".c16"}, 32'(bus.fe2de_rv16), 32'(c16));
      chk({tag, ".cross"}, 32'(bus.cross_bd_ff), 32'(cb));
      chk({tag, ".addr"}, bus.imem_addr, addr);
   endtask

   // Drive one cycle's inputs just after the edge, return at the following negedge.
   task automatic step(input logic s, input logic r, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      bus.fet_stall   = s;
      bus.redirect    = r;
      bus.redirect_pc = rpc;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      cpurst_n        = 1'b0;
      bus.fet_stall   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      @(negedge clk);
      expect_out("rst", 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      cpurst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mpc;
   logic        mbub;

   function automatic logic [15:0] half_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[8:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic model_check(input logic s, input logic r, input logic [31:0] rpc);
      logic [15:0] h;
      logic        ev, ec16, ecb, nbub;
      logic [31:0] e32, npc, eaddr, need;
      logic [15:0] e16;
      if (r) begin
         chk("rnd.redir.valid", 32'(bus.fet_valid), 32'h0);
         chk("rnd.redir.rv32", bus.rv32_instr_todec, 32'h0);
         chk("rnd.redir.cross", 32'(bus.cross_bd_ff), 32'h0);
         chk("rnd.redir.addr", bus.imem_addr, {rpc[31:2], 2'b00});
         mpc  = {rpc[31:1], 1'b0};
         mbub = 1'b0;
      end else begin
         h = half_at(mpc);
         if (h[1:0] != 2'b11) begin
            ev = 1'b1; e32 = {16'h0, h}; e16 = h; ec16 = 1'b1; ecb = 1'b0;
            npc = mpc + 32'd2; nbub = 1'b0;
         end else if (mpc[1] && !mbub) begin
            ev = 1'b0; e32 = 32'h0; e16 = 16'h0; ec16 = 1'b0; ecb = 1'b1;
            npc = mpc; nbub = 1'b1;
         end else begin
            ev = 1'b1; e32 = {half_at(mpc + 32'd2), h}; e16 = 16'h0; ec16 = 1'b0; ecb = 1'b0;
            npc = mpc + 32'd4; nbub = 1'b0;
         end
         // Memory address = word holding the first halfword needed on the next cycle.
         if (s) need = mbub ? mpc + 32'd2 : mpc;
         else   need = nbub ? npc + 32'd2 : npc;
         eaddr = {need[31:2], 2'b00};
         expect_out("rnd", ev, mpc, e32, e16, ec16, ecb, eaddr);
         if (!s) begin
            mpc  = npc;
            mbub = nbub;
         end
      end
   endtask

   initial begin
      logic        rs, rr;
      logic [31:0] rpc;
      logic [15:0] hv;
      errors          = 0;
      checks          = 0;
      cpurst_n        = 1'b0;
      bus.fet_stall   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      // Two aligned 32-bit instructions.
      clear_mem();
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h00A0_0093;
      reset_dut();
      expect_out("t1a", 1'b1, 32'h0, 32'h0000_0013, 16'h0, 1'b0, 1'b0, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t1b", 1'b1, 32'h4, 32'h00A0_0093, 16'h0, 1'b0, 1'b0, 32'h8);

      // Compressed pair in one word.
      clear_mem();
      mem[0] = 32'h4501_4581;
      reset_dut();
      expect_out("t2a", 1'b1, 32'h0, 32'h0000_4581, 16'h4581, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t2b", 1'b1, 32'h2, 32'h0000_4501, 16'h4501, 1'b1, 1'b0, 32'h4);

      // Boundary-crossing 32-bit instruction.
      clear_mem();
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h1111_0000;
      reset_dut();
      expect_out("t3a", 1'b1, 32'h0, 32'h0000_4501, 16'h4501, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t3b", 1'b0, 32'h2, 32'h0, 16'h0, 1'b0, 1'b1, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t3c", 1'b1, 32'h2, 32'h0000_0013, 16'h0, 1'b0, 1'b0, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t3d", 1'b1, 32'h6, 32'h0000_1111, 16'h1111, 1'b1, 1'b0, 32'h8);

      // Stall held three cycles, then redirect during a stall.
      clear_mem();
      mem[0]  = 32'h0000_0013;
      mem[1]  = 32'h00A0_0093;
      mem[2]  = 32'h0010_0113;
      mem[3]  = 32'h0020_0193;
      mem[64] = 32'h4585_0013;
      reset_dut();
      expect_out("t4a", 1'b1, 32'h0, 32'h0000_0013, 16'h0, 1'b0, 1'b0, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t4b", 1'b1, 32'h4, 32'h00A0_0093, 16'h0, 1'b0, 1'b0, 32'h8);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         expect_out("t4stall", 1'b1, 32'h8, 32'h0010_0113, 16'h0, 1'b0, 1'b0, 32'h8);
      end
      step(1'b0, 1'b0, 32'h0);
      expect_out("t4c", 1'b1, 32'h8, 32'h0010_0113, 16'h0, 1'b0, 1'b0, 32'hC);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t4d", 1'b1, 32'hC, 32'h0020_0193, 16'h0, 1'b0, 1'b0, 32'h10);
      step(1'b1, 1'b1, 32'h0000_0102);
      chk("t5.redir.valid", 32'(bus.fet_valid), 32'h0);
      chk("t5.redir.rv32", bus.rv32_instr_todec, 32'h0);
      chk("t5.redir.addr", bus.imem_addr, 32'h0000_0100);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t5b", 1'b1, 32'h102, 32'h0000_4585, 16'h4585, 1'b1, 1'b0, 32'h104);

      // Reset while a crossing is in flight.
      clear_mem();
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h1111_0000;
      reset_dut();
      expect_out("t6a", 1'b1, 32'h0, 32'h0000_4501, 16'h4501, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      expect_out("t6b", 1'b0, 32'h2, 32'h0, 16'h0, 1'b0, 1'b1, 32'h4);
      reset_dut();
      expect_out("t6c", 1'b1, 32'h0, 32'h0000_4501, 16'h4501, 1'b1, 1'b0, 32'h0);

      // Random mix of RV16/RV32 halfwords with random stalls and redirects.
      for (int i = 0; i < 128; i++) begin
         for (int k = 0; k < 2; k++) begin
            hv = 16'($urandom);
            if ($urandom_range(1) == 0) hv[1:0] = 2'b11;
            else                        hv[1:0] = 2'($urandom_range(2));
            if (k == 0) mem[i][15:0] = hv;
            else        mem[i][31:16] = hv;
         end
      end
      reset_dut();
      mpc  = 32'h0;
      mbub = 1'b0;
      model_check(1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 400; c++) begin
         rr  = ($urandom_range(15) == 0);
         rs  = ($urandom_range(4) == 0);
         rpc = 32'($urandom_range(255)) << 1;
         step(rs, rr, rpc);
         model_check(rs, rr, rpc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fet_align.md
# fet_align

Fetch-alignment stage that sits directly upstream of the fetch/decode pipeline register. It turns the 32-bit words returned by the instruction memory into a stream of RV32 and RV16 instructions, each tagged with its PC. It handles compressed instructions and 32-bit instructions that straddle a word boundary, and it drives the instruction-memory address. Its outputs feed `fetch_pc`, `rv32_instr_todec`, `rv16_instr_todec`, `fe2de_rv16` and `cross_bd_ff` of the decode register.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be halfword aligned.
- clk  in  1  single clock, all state on rising edge.
- cpurst_n  in  1  reset, synchronous, active-low.
- redirect  in  1  flush/branch redirect; has priority over stall.
- redirect_pc  in  32  new PC, halfword aligned (bit 0 ignored).
- fet_stall  in  1  downstream stall; hold everything.
- imem_rdata  in  32  word read at the address sampled on the previous edge (fixed 1-cycle synchronous ROM/TCM).
- imem_addr  out  32  word address to read, combinational, bits[1:0]=0.
- fetch_pc  out  32  PC of the presented instruction.
- rv32_instr_todec  out  32  full 32-bit instruction, or zero-extended halfword if compressed, 0 when invalid.
- rv16_instr_todec  out  16  raw compressed halfword, 0 otherwise.
- fe2de_rv16  out  1  presented instruction is compressed.
- cross_bd_ff  out  1  bubble cycle while the second half of a boundary-crossing instruction is fetched.
- fet_valid  out  1  outputs carry a real instruction.

## Operation
- Registers: `state` ∈ {ALIGN, ODD, CROSS}, `pc[31:0]`, `rd_addr[31:0]` (address whose data is on imem_rdata), `lo_buf[15:0]`.
- imem_addr selection:
  - redirect → {redirect_pc[31:2],2'b00}.
  - else stall → rd_addr.
  - else consume → rd_addr+4.
  - else rd_addr.
  - Memory samples imem_addr each edge; rd_addr <= imem_addr every non-reset edge.
- ALIGN (halfword = rdata[15:0]):
  - If rdata[1:0]==2'b11: present rdata as 32-bit, pc+=4, consume, stay ALIGN.
  - Else: present compressed rdata[15:0], pc+=2, no consume, go ODD.
- ODD (halfword = rdata[31:16]):
  - If rdata[17:16]!=2'b11: present compressed, pc+=2, consume, go ALIGN.
  - Else: lo_buf<=rdata[31:16], consume, go CROSS. This cycle fet_valid=0, cross_bd_ff=1, rv32_instr_todec=0, fe2de_rv16=0, fetch_pc=pc.
- CROSS: present {rdata[15:0],lo_buf} as 32-bit with fetch_pc=pc, pc+=4, no consume, go ODD.
- Redirect (any state, stall ignored):
  - pc<=redirect_pc, state<=redirect_pc[1]?ODD:ALIGN, lo_buf unchanged.
  - Outputs this cycle: fet_valid=0, rv32_instr_todec=0, cross_bd_ff=0.
- Stall without redirect: no register changes; imem_addr=rd_addr, so rdata and all outputs stay stable.
- Arithmetic: pc and address increments wrap modulo 2^32; wraparound from 32'hFFFF_FFFC to 0 is legal and unflagged.

## Timing
- Reset (cpurst_n=0 at edge):
  - pc<=RESET_PC, rd_addr<=align(RESET_PC), state<=RESET_PC[1]?ODD:ALIGN.
  - During reset: imem_addr=align(RESET_PC), fet_valid=0, rv32_instr_todec=0, rv16_instr_todec=0, fe2de_rv16=0, cross_bd_ff=0, fetch_pc=RESET_PC.
- First valid instruction: first cycle after reset release.
- Redirect latency: 1 cycle. The target instruction is presented the cycle after redirect, or 2 cycles after if the target is an ODD 32-bit crossing.
- Throughput: one instruction per cycle, except one bubble per boundary-crossing 32-bit instruction.
- Reset mid-CROSS discards lo_buf contents; no partial instruction is ever emitted.
- Redirect coincident with fet_stall: redirect wins; state is loaded.

## Structure
- Shared fetch package: state encoding (ALIGN=2'd0, ODD=2'd1, CROSS=2'd2), the `is_rv32(half)` predicate (half[1:0]==2'b11), and the NOP/zero constants.
- Single module. No sub-module; RVC-to-RV32 expansion remains in the existing expander outside this block.

## Test plan
- Reset with RESET_PC=0, words @0=32'h00000013 and @4=32'h00A00093:
  - fet_valid=1, pc=0 then pc=4.
  - imem_addr 0,4,8.
  - fe2de_rv16=0.
- Compressed pair, word @0=32'h45014581:
  - pc=0, rv16=16'h4581; then pc=2, rv16=16'h4501.
  - imem_addr advances to 4 only in the second cycle.
- Crossing, @0=32'h00134501, @4=32'h11110000:
  - pc=0 rv16=16'h4501.
  - Bubble with cross_bd_ff=1.
  - pc=2 instr=32'h00000013, then state ODD at pc=6.
- fet_stall held 3 cycles mid-stream: fetch_pc, instr and imem_addr stay constant; the stream resumes without loss or duplication.
- redirect to 32'h0000_0102 during a stall → imem_addr=32'h100 that cycle, fet_valid=0; next cycle fetch_pc=32'h102 from rdata[31:16].
- cpurst_n low during the CROSS bubble → after release pc=RESET_PC; no instruction built from the stale lo_buf appears.
